// File: rtl/pc_pkg.sv
// Shared types for the fetch program-counter unit.
// Next-PC source select and RAS sizing defaults.
package pc_pkg;

    typedef enum logic [2:0] {
        PC_SEQ,
        PC_JUMP,
        PC_CALL,
        PC_RET,
        PC_BRANCH,
        PC_EXC,
        PC_HOLD
    } pc_sel_t;

    localparam int RAS_DEPTH_DEF = 4;

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack; a push when full drops the oldest entry.
// push+pop together replaces the top in place.
import pc_pkg::*;

module ras_stack #(
    parameter int WIDTH     = 32,
    parameter int RAS_DEPTH = RAS_DEPTH_DEF
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       clear,
    input  logic [WIDTH-1:0]           push_data,
    output logic [WIDTH-1:0]           top,
    output logic [$clog2(RAS_DEPTH):0] count,
    output logic                       empty,
    output logic                       full
);

    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem [RAS_DEPTH];
    logic [PW-1:0]    ptr;
    logic [PW-1:0]    ptr_inc;
    logic [PW-1:0]    ptr_dec;
    logic [PW-1:0]    wr_idx;
    logic [CW-1:0]    cnt;
    logic             do_pop;
    logic             do_push;

    assign empty   = (cnt == '0);
    assign full    = (cnt == CW'(RAS_DEPTH));
    assign top     = mem[ptr];
    assign count   = cnt;
    assign ptr_inc = ptr + 1'b1;
    assign ptr_dec = ptr - 1'b1;

    // A pop on an empty stack is dropped; push+pop then degrades to a push.
    assign do_pop  = pop && !empty && !clear;
    assign do_push = push && !clear;
    assign wr_idx  = do_pop ? ptr : ptr_inc;

    always_ff @(negedge clock or posedge reset) begin
        if (reset) begin
            ptr <= '0;
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else begin
            unique case ({do_push, do_pop})
                2'b10: begin
                    ptr <= ptr_inc;
                    if (!full) cnt <= cnt + 1'b1;
                end
                2'b01: begin
                    ptr <= ptr_dec;
                    cnt <= cnt - 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(negedge clock) begin
        if (do_push) mem[wr_idx] <= push_data;
    end

endmodule

// File: rtl/pc_unit.sv
// Fetch PC register with prioritised next-PC select and a return-address stack.
// State updates on the falling clock edge.
import pc_pkg::*;

module pc_unit #(
    parameter int               WIDTH        = 32,
    parameter int               INC          = 1,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
    parameter logic [WIDTH-1:0] EXC_VECTOR   = WIDTH'(32'h80),
    parameter int               RAS_DEPTH    = RAS_DEPTH_DEF
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       pc_write,
    input  logic                       exc_req,
    input  logic                       branch_taken,
    input  logic [WIDTH-1:0]           branch_target,
    input  logic                       jump,
    input  logic                       call,
    input  logic                       ret,
    input  logic [WIDTH-1:0]           jump_target,
    output logic [WIDTH-1:0]           pc_out,
    output logic [WIDTH-1:0]           pc_plus,
    output logic [$clog2(RAS_DEPTH):0] ras_count,
    output logic                       ret_underflow
);

    pc_sel_t          sel;
    logic [WIDTH-1:0] pc_next;
    logic [WIDTH-1:0] ras_top;
    logic             ras_empty;
    logic             unused_ras_full;
    logic             ras_push;
    logic             ras_pop;
    logic             ras_clear;
    logic             underflow_next;

    assign pc_plus = pc_out + WIDTH'(INC);

    always_comb begin
        if (exc_req)           sel = PC_EXC;
        else if (branch_taken) sel = PC_BRANCH;
        else if (!pc_write)    sel = PC_HOLD;
        else if (ret)          sel = PC_RET;
        else if (call)         sel = PC_CALL;
        else if (jump)         sel = PC_JUMP;
        else                   sel = PC_SEQ;
    end

    always_comb begin
        pc_next        = pc_plus;
        ras_push       = 1'b0;
        ras_pop        = 1'b0;
        ras_clear      = 1'b0;
        underflow_next = 1'b0;
        unique case (sel)
            PC_EXC: begin
                pc_next   = EXC_VECTOR;
                ras_clear = 1'b1;
            end
            PC_BRANCH: pc_next = branch_target;
            PC_HOLD:   pc_next = pc_out;
            PC_RET: begin
                // call+ret pops the old top and pushes the new return address.
                pc_next        = ras_empty ? pc_plus : ras_top;
                ras_pop        = 1'b1;
                ras_push       = call;
                underflow_next = ras_empty;
            end
            PC_CALL: begin
                pc_next  = jump_target;
                ras_push = 1'b1;
            end
            PC_JUMP: pc_next = jump_target;
            default: pc_next = pc_plus;
        endcase
    end

    always_ff @(negedge clock or posedge reset) begin
        if (reset) begin
            pc_out        <= RESET_VECTOR;
            ret_underflow <= 1'b0;
        end else begin
            pc_out        <= pc_next;
            ret_underflow <= underflow_next;
        end
    end

    ras_stack #(
        .WIDTH     (WIDTH),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clock     (clock),
        .reset     (reset),
        .push      (ras_push),
        .pop       (ras_pop),
        .clear     (ras_clear),
        .push_data (pc_plus),
        .top       (ras_top),
        .count     (ras_count),
        .empty     (ras_empty),
        .full      (unused_ras_full)
    );

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit with a scoreboard of expected PC/RAS state.
// Inputs change on the rising edge; results are checked after the falling edge.
module tb_pc_unit;

    logic        clock;
    logic        reset;
    logic        pc_write;
    logic        exc_req;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic        call;
    logic        ret;
    logic [31:0] jump_target;
    logic [31:0] pc_out;
    logic [31:0] pc_plus;
    logic [2:0]  ras_count;
    logic        ret_underflow;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [31:0] pc;
        logic [2:0]  cnt;
        logic        uf;
    } exp_t;

    exp_t sb[$];

    pc_unit dut (
        .clock         (clock),
        .reset         (reset),
        .pc_write      (pc_write),
        .exc_req       (exc_req),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .call          (call),
        .ret           (ret),
        .jump_target   (jump_target),
        .pc_out        (pc_out),
        .pc_plus       (pc_plus),
        .ras_count     (ras_count),
        .ret_underflow (ret_underflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_state(input exp_t e);
        checks++;
        assert (pc_out === e.pc) else begin
            failures++;
            $error("FAIL pc_out got %h want %h", pc_out, e.pc);
        end
        checks++;
        assert (ras_count === e.cnt) else begin
            failures++;
            $error("FAIL ras_count got %0d want %0d", ras_count, e.cnt);
        end
        checks++;
        assert (ret_underflow === e.uf) else begin
            failures++;
            $error("FAIL ret_underflow got %b want %b", ret_underflow, e.uf);
        end
        checks++;
        assert (pc_plus === e.pc + 32'd1) else begin
            failures++;
            $error("FAIL pc_plus got %h want %h", pc_plus, e.pc + 32'd1);
        end
    endtask

    task automatic cyc(
        input logic pw, input logic ex, input logic br,
        input logic [31:0] bt,
        input logic j, input logic c, input logic r,
        input logic [31:0] jt,
        input logic [31:0] epc, input logic [2:0] ecnt, input logic euf
    );
        pc_write      = pw;
        exc_req       = ex;
        branch_taken  = br;
        branch_target = bt;
        jump          = j;
        call          = c;
        ret           = r;
        jump_target   = jt;
        sb.push_back(exp_t'{epc, ecnt, euf});
        @(negedge clock);
        #1;
        check_state(sb.pop_front());
        @(posedge clock);
    endtask

    task automatic seq(input logic [31:0] epc, input logic [2:0] ecnt, input logic euf);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, epc, ecnt, euf);
    endtask

    task automatic jmp(input logic [31:0] t, input logic [2:0] ecnt);
        cyc(1, 0, 0, 0, 1, 0, 0, t, t, ecnt, 0);
    endtask

    task automatic do_call(input logic [31:0] t, input logic [2:0] ecnt);
        cyc(1, 0, 0, 0, 0, 1, 0, t, t, ecnt, 0);
    endtask

    task automatic do_ret(input logic [31:0] epc, input logic [2:0] ecnt, input logic euf);
        cyc(1, 0, 0, 0, 0, 0, 1, 0, epc, ecnt, euf);
    endtask

    initial begin
        reset = 1'b1;
        pc_write = 1'b1;
        exc_req = 1'b0;
        branch_taken = 1'b0;
        branch_target = '0;
        jump = 1'b0;
        call = 1'b0;
        ret = 1'b0;
        jump_target = '0;

        #12;
        check_state(exp_t'{32'd0, 3'd0, 1'b0});
        @(posedge clock);
        reset = 1'b0;

        seq(1, 0, 0);
        seq(2, 0, 0);
        seq(3, 0, 0);

        // asynchronous reset mid-cycle
        #1 reset = 1'b1;
        #1 check_state(exp_t'{32'd0, 3'd0, 1'b0});
        @(posedge clock);
        reset = 1'b0;

        // stall blocks jump, branch overrides stall
        jmp(5, 0);
        cyc(0, 0, 0, 0, 1, 0, 0, 40, 5, 0, 0);
        cyc(0, 0, 0, 0, 1, 0, 0, 40, 5, 0, 0);
        cyc(0, 0, 1, 20, 0, 0, 0, 0, 20, 0, 0);

        // simple call / return
        jmp(10, 0);
        do_call(100, 1);
        do_ret(11, 0, 0);

        // overflow then underflow of a 4-entry stack
        jmp(1, 0);
        do_call(2, 1);
        do_call(3, 2);
        do_call(4, 3);
        do_call(5, 4);
        do_call(50, 4);
        do_ret(6, 3, 0);
        do_ret(5, 2, 0);
        do_ret(4, 1, 0);
        do_ret(3, 0, 0);
        do_ret(4, 0, 1);
        seq(5, 0, 0);

        // call+ret in one cycle, with and without entries
        do_call(200, 1);
        cyc(1, 0, 0, 0, 0, 1, 1, 300, 6, 1, 0);
        do_ret(201, 0, 0);
        cyc(1, 0, 0, 0, 0, 1, 1, 300, 202, 1, 1);
        do_ret(202, 0, 0);

        // stalled call leaves no trace
        cyc(0, 0, 0, 0, 0, 1, 0, 999, 202, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 1, 0, 202, 0, 0);

        // exception beats branch and clears the stack
        do_call(10, 1);
        do_call(20, 2);
        cyc(1, 1, 1, 7, 0, 0, 0, 0, 32'h80, 0, 0);
        do_ret(32'h81, 0, 1);

        // wrap-around and zero target
        jmp(32'hFFFF_FFFF, 0);
        seq(0, 0, 0);
        seq(1, 0, 0);
        jmp(0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pc_unit.md
# pc_unit

- Parametrised program-counter unit for the pipelined CPU.
- Holds the fetch PC and selects the next PC from several sources:
  - sequential increment;
  - jump, call and return;
  - resolved-branch redirect and exception vector.
- Adds a small return-address stack (RAS), stall handling and redirect priority.
- Sits at the front of the IF stage and drives the instruction-memory address and the IF/ID PC.

## Interface
Parameters:
- WIDTH, 32, PC and target width in bits.
- INC, 1, sequential increment (instruction-index addressing).
- RESET_VECTOR, 0, PC value loaded on reset.
- EXC_VECTOR, 32'h80, PC value loaded on an exception.
- RAS_DEPTH, 4, return-address-stack entries (power of two, ≥2).

Ports:
- clock  input  1  system clock; all state updates on the falling edge.
- reset  input  1  asynchronous, active-high reset.
- pc_write  input  1  0 = hazard stall; holds the PC unless an exception or branch redirect occurs.
- exc_req  input  1  exception redirect to EXC_VECTOR.
- branch_taken  input  1  resolved taken branch (EX stage).
- branch_target  input  WIDTH  branch destination.
- jump  input  1  unconditional jump (ID stage).
- call  input  1  jump-and-link; pushes the return address.
- ret  input  1  return; pops the RAS.
- jump_target  input  WIDTH  destination for jump and call.
- pc_out  output  WIDTH  current fetch PC (registered).
- pc_plus  output  WIDTH  pc_out+INC (combinational).
- ras_count  output  $clog2(RAS_DEPTH)+1  valid RAS entries.
- ret_underflow  output  1  one-cycle pulse: ret with an empty RAS.

## Operation
Next-PC priority, highest first:
1. exc_req → EXC_VECTOR. RAS cleared (count=0). Applied regardless of pc_write.
2. branch_taken → branch_target. RAS untouched. Applied regardless of pc_write.
3. pc_write=0 → hold pc_out. RAS untouched. jump, call and ret are ignored.
4. ret (with or without call) → popped address. See the RAS rules below.
5. call → jump_target. Push pc_plus.
6. jump → jump_target.
7. Otherwise → pc_plus.

General rules:
- call, ret and jump take effect only when their priority level is selected. A lost request leaves no side effect.
- Arithmetic wraps modulo 2^WIDTH. A target value of 0 is legal and is loaded like any other.

RAS rules:
- Push when full: the oldest entry is overwritten (circular). Count stays at RAS_DEPTH.
- Pop when empty: the next PC is pc_plus, ret_underflow pulses and count stays 0.
- call+ret in the same cycle: pop then push. The next PC is the popped top, the top is replaced by pc_plus and count is unchanged.
  - If the RAS is empty in this case: next PC = pc_plus, count becomes 1 and ret_underflow pulses.

## Timing
- Reset (asynchronous, immediate):
  - pc_out=RESET_VECTOR, ras_count=0, ret_underflow=0.
  - RAS contents are don't-care.
- Reset deasserted mid-cycle: the first update occurs at the next falling edge.
- Latency: the selected next PC appears on pc_out after exactly one falling edge. pc_plus follows pc_out combinationally.
- ret_underflow is registered. It is high for exactly one cycle after the offending edge.
- A held PC (stall) keeps pc_out and the RAS bit-identical for any number of cycles.

## Structure
- Package pc_pkg:
  - enum pc_sel_t {PC_SEQ, PC_JUMP, PC_CALL, PC_RET, PC_BRANCH, PC_EXC, PC_HOLD};
  - default RAS_DEPTH constant.
- Next-PC selection is a combinational priority encoder producing pc_sel_t, feeding one registered PC.
- Sub-module ras_stack:
  - parametrised by WIDTH and RAS_DEPTH;
  - inputs: push, pop, push_data, clear;
  - outputs: top, count, empty, full;
  - circular top pointer.

## Test plan
- Reset, then 3 edges with pc_write=1 and INC=1 → pc_out 0,1,2,3. Assert reset mid-run → pc_out=0 immediately.
- pc_out=5, pc_write=0 and jump=1 (target 40) for 2 cycles → pc_out stays 5. Then branch_taken=1 (target 20) with pc_write=0 → pc_out=20.
- pc_out=10, call (target 100), then ret → pc_out 100, then 11. ras_count goes 1, then 0.
- RAS_DEPTH=4, five nested calls from pc_out 1,2,3,4,5 → ras_count=4. Five rets return 6,5,4,3, then pc_plus with a ret_underflow pulse.
- exc_req and branch_taken together with 2 RAS entries → pc_out=EXC_VECTOR, ras_count=0.
- pc_out=2^WIDTH-1 with sequential fetch → pc_out wraps to 0. Then jump to target 0 → pc_out=0 loaded.
